// File: rtl/range_counter_if.sv
// Control and status bundle for range_counter.
// The master drives the controls; the slave (the counter) drives the status.
interface range_counter_if #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned LAP_WIDTH = 8
);
  logic                 enable;
  logic [1:0]           mode;
  logic                 load;
  logic [WIDTH-1:0]     load_value;
  logic [WIDTH-1:0]     out;
  logic                 dir;
  logic                 tc;
  logic [LAP_WIDTH-1:0] lap_count;

  modport master (
    output enable,
    output mode,
    output load,
    output load_value,
    input  out,
    input  dir,
    input  tc,
    input  lap_count
  );

  modport slave (
    input  enable,
    input  mode,
    input  load,
    input  load_value,
    output out,
    output dir,
    output tc,
    output lap_count
  );
endinterface

// File: rtl/range_counter.sv
// Bounded counter with wrap-up, wrap-down, saturate and ping-pong modes,
// clamped load, terminal-count pulse and lap counter.
module range_counter #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] MIN_VALUE = 8'd10,
  parameter logic [WIDTH-1:0] MAX_VALUE = 8'd13,
  parameter int unsigned      STEP      = 1,
  parameter int unsigned      LAP_WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  range_counter_if.slave  bus
);

  typedef enum logic [1:0] {
    M_UP   = 2'b00,
    M_DOWN = 2'b01,
    M_SAT  = 2'b10,
    M_PING = 2'b11
  } mode_e;

  localparam logic [WIDTH:0]   STEP_W   = (WIDTH+1)'(STEP);
  localparam logic [WIDTH-1:0] STEP_N   = WIDTH'(STEP);
  localparam logic [WIDTH:0]   MIN_W    = {1'b0, MIN_VALUE};
  localparam logic [WIDTH:0]   MAX_W    = {1'b0, MAX_VALUE};
  localparam logic [WIDTH:0]   MIN_STEP = MIN_W + STEP_W;

  logic [WIDTH-1:0]     cnt_q;
  logic [WIDTH-1:0]     cnt_d;
  logic                 dir_q;
  logic                 dir_d;
  logic                 tc_q;
  logic                 tc_d;
  logic [LAP_WIDTH-1:0] lap_q;
  logic [LAP_WIDTH-1:0] lap_d;
  logic [WIDTH:0]       cur_w;
  logic [WIDTH:0]       up_w;
  logic [WIDTH-1:0]     clamp_v;
  mode_e                mode;

  assign mode  = mode_e'(bus.mode);
  // One extra bit so out + STEP never wraps at the top of the range.
  assign cur_w = {1'b0, cnt_q};
  assign up_w  = cur_w + STEP_W;

  always_comb begin
    clamp_v = bus.load_value;
    unique case (1'b1)
      (bus.load_value < MIN_VALUE): clamp_v = MIN_VALUE;
      (bus.load_value > MAX_VALUE): clamp_v = MAX_VALUE;
      default:                      clamp_v = bus.load_value;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    dir_d = dir_q;
    tc_d  = 1'b0;
    if (bus.load) begin
      cnt_d = clamp_v;
      unique case (mode)
        M_UP:   dir_d = 1'b1;
        M_DOWN: dir_d = 1'b0;
        M_SAT:  dir_d = 1'b1;
        M_PING: dir_d = dir_q;
      endcase
    end else if (bus.enable) begin
      unique case (mode)
        M_UP: begin
          dir_d = 1'b1;
          if (up_w > MAX_W) begin
            cnt_d = MIN_VALUE;
            tc_d  = 1'b1;
          end else begin
            cnt_d = up_w[WIDTH-1:0];
          end
        end
        M_DOWN: begin
          dir_d = 1'b0;
          if (cur_w < MIN_STEP) begin
            cnt_d = MAX_VALUE;
            tc_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - STEP_N;
          end
        end
        M_SAT: begin
          dir_d = 1'b1;
          if (up_w >= MAX_W) begin
            cnt_d = MAX_VALUE;
            tc_d  = (cnt_q != MAX_VALUE);
          end else begin
            cnt_d = up_w[WIDTH-1:0];
          end
        end
        M_PING: begin
          // Landing on a bound turns around and pulses tc.
          if (dir_q) begin
            if (up_w >= MAX_W) begin
              cnt_d = MAX_VALUE;
              dir_d = 1'b0;
              tc_d  = 1'b1;
            end else begin
              cnt_d = up_w[WIDTH-1:0];
            end
          end else begin
            if (cur_w <= MIN_STEP) begin
              cnt_d = MIN_VALUE;
              dir_d = 1'b1;
              tc_d  = 1'b1;
            end else begin
              cnt_d = cnt_q - STEP_N;
            end
          end
        end
      endcase
    end
  end

  assign lap_d = lap_q + LAP_WIDTH'(tc_d);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= MIN_VALUE;
      dir_q <= 1'b1;
      tc_q  <= 1'b0;
      lap_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      dir_q <= dir_d;
      tc_q  <= tc_d;
      lap_q <= lap_d;
    end
  end

  assign bus.out       = cnt_q;
  assign bus.dir       = dir_q;
  assign bus.tc        = tc_q;
  assign bus.lap_count = lap_q;

endmodule

// File: tb/tb_range_counter.sv
// Directed bench for range_counter: STEP=1 instance for most modes,
// STEP=2 instance for the saturate landing case.
module tb_range_counter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  range_counter_if #(.WIDTH(8), .LAP_WIDTH(8)) b1 ();
  range_counter_if #(.WIDTH(8), .LAP_WIDTH(8)) b2 ();

  range_counter #(
    .WIDTH(8), .MIN_VALUE(8'd10), .MAX_VALUE(8'd13),
    .STEP(1), .LAP_WIDTH(8)
  ) dut (
    .clk(clk), .rst(rst), .bus(b1.slave)
  );

  range_counter #(
    .WIDTH(8), .MIN_VALUE(8'd10), .MAX_VALUE(8'd13),
    .STEP(2), .LAP_WIDTH(8)
  ) dut2 (
    .clk(clk), .rst(rst), .bus(b2.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (b1.out !== 8'd10) begin
      n_err++;
      $display("FAIL reset_out got %0d exp 10", b1.out);
    end
    n_cmp++;
    if (b1.dir !== 1'b1) begin
      n_err++;
      $display("FAIL reset_dir got %b exp 1", b1.dir);
    end
    n_cmp++;
    if (b1.tc !== 1'b0) begin
      n_err++;
      $display("FAIL reset_tc got %b exp 0", b1.tc);
    end
    n_cmp++;
    if (b1.lap_count !== 8'd0) begin
      n_err++;
      $display("FAIL reset_lap got %0d exp 0", b1.lap_count);
    end
  endtask

  task automatic test_wrap_up();
    logic [7:0] eo [5] = '{8'd11, 8'd12, 8'd13, 8'd10, 8'd11};
    logic       et [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    do_reset();
    b1.mode   = 2'b00;
    b1.enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (b1.out !== eo[i] || b1.tc !== et[i]) begin
        n_err++;
        $display("FAIL wrap_up[%0d] got out=%0d tc=%b exp out=%0d tc=%b",
                 i, b1.out, b1.tc, eo[i], et[i]);
      end
    end
    b1.enable = 1'b0;
    n_cmp++;
    if (b1.lap_count !== 8'd1) begin
      n_err++;
      $display("FAIL wrap_up_lap got %0d exp 1", b1.lap_count);
    end
  endtask

  task automatic test_ping_pong();
    logic [7:0] eo [8] = '{8'd11, 8'd12, 8'd13, 8'd12,
                           8'd11, 8'd10, 8'd11, 8'd12};
    logic       et [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic       ed [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    do_reset();
    b1.mode   = 2'b11;
    b1.enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_cmp++;
      if (b1.out !== eo[i] || b1.tc !== et[i] || b1.dir !== ed[i]) begin
        n_err++;
        $display("FAIL ping_pong[%0d] got out=%0d tc=%b dir=%b exp %0d %b %b",
                 i, b1.out, b1.tc, b1.dir, eo[i], et[i], ed[i]);
      end
    end
    b1.enable = 1'b0;
    n_cmp++;
    if (b1.lap_count !== 8'd2) begin
      n_err++;
      $display("FAIL ping_pong_lap got %0d exp 2", b1.lap_count);
    end
  endtask

  task automatic test_saturate();
    logic [7:0] eo [4] = '{8'd12, 8'd13, 8'd13, 8'd13};
    logic       et [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    do_reset();
    b2.mode   = 2'b10;
    b2.enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if (b2.out !== eo[i] || b2.tc !== et[i]) begin
        n_err++;
        $display("FAIL saturate[%0d] got out=%0d tc=%b exp out=%0d tc=%b",
                 i, b2.out, b2.tc, eo[i], et[i]);
      end
    end
    b2.enable = 1'b0;
    n_cmp++;
    if (b2.lap_count !== 8'd1 || b2.dir !== 1'b1) begin
      n_err++;
      $display("FAIL saturate_lap got lap=%0d dir=%b exp lap=1 dir=1",
               b2.lap_count, b2.dir);
    end
  endtask

  task automatic test_load();
    logic [7:0] lv [4] = '{8'd3, 8'd200, 8'd11, 8'd255};
    logic [7:0] eo [4] = '{8'd10, 8'd13, 8'd11, 8'd13};
    logic [1:0] md [4] = '{2'b00, 2'b00, 2'b10, 2'b01};
    logic       ed [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    // Reset then one wrap-up lap leaves lap_count at 1 going in.
    do_reset();
    b1.mode   = 2'b00;
    b1.enable = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    for (int i = 0; i < 4; i++) begin
      b1.mode       = md[i];
      b1.load       = 1'b1;
      b1.load_value = lv[i];
      tick();
      n_cmp++;
      if (b1.out !== eo[i] || b1.tc !== 1'b0 || b1.dir !== ed[i] ||
          b1.lap_count !== 8'd1) begin
        n_err++;
        $display("FAIL load[%0d] got out=%0d tc=%b dir=%b lap=%0d exp %0d 0 %b 1",
                 i, b1.out, b1.tc, b1.dir, b1.lap_count, eo[i], ed[i]);
      end
    end
    b1.load   = 1'b0;
    b1.enable = 1'b0;
  endtask

  task automatic test_pp_boundary();
    do_reset();
    b1.mode       = 2'b11;
    b1.load       = 1'b1;
    b1.load_value = 8'd13;
    tick();
    b1.load   = 1'b0;
    b1.enable = 1'b1;
    tick();
    n_cmp++;
    if (b1.out !== 8'd13 || b1.dir !== 1'b0 || b1.tc !== 1'b1) begin
      n_err++;
      $display("FAIL pp_max got out=%0d dir=%b tc=%b exp 13 0 1",
               b1.out, b1.dir, b1.tc);
    end
    b1.enable     = 1'b0;
    b1.load       = 1'b1;
    b1.load_value = 8'd10;
    tick();
    b1.load   = 1'b0;
    b1.enable = 1'b1;
    tick();
    n_cmp++;
    if (b1.out !== 8'd10 || b1.dir !== 1'b1 || b1.tc !== 1'b1 ||
        b1.lap_count !== 8'd2) begin
      n_err++;
      $display("FAIL pp_min got out=%0d dir=%b tc=%b lap=%0d exp 10 1 1 2",
               b1.out, b1.dir, b1.tc, b1.lap_count);
    end
    b1.enable = 1'b0;
  endtask

  task automatic test_mid_run();
    do_reset();
    b1.mode   = 2'b11;
    b1.enable = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    b1.enable = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++;
      if (b1.out !== 8'd12 || b1.dir !== 1'b0 || b1.tc !== 1'b0 ||
          b1.lap_count !== 8'd1) begin
        n_err++;
        $display("FAIL hold[%0d] got out=%0d dir=%b tc=%b lap=%0d exp 12 0 0 1",
                 i, b1.out, b1.dir, b1.tc, b1.lap_count);
      end
    end
    b1.enable     = 1'b1;
    b1.load       = 1'b1;
    b1.load_value = 8'd12;
    rst           = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++;
      if (b1.out !== 8'd10 || b1.dir !== 1'b1 || b1.tc !== 1'b0 ||
          b1.lap_count !== 8'd0) begin
        n_err++;
        $display("FAIL mid_rst[%0d] got out=%0d dir=%b tc=%b lap=%0d exp 10 1 0 0",
                 i, b1.out, b1.dir, b1.tc, b1.lap_count);
      end
    end
    rst     = 1'b0;
    b1.load = 1'b0;
    tick();
    n_cmp++;
    if (b1.out !== 8'd11 || b1.dir !== 1'b1) begin
      n_err++;
      $display("FAIL restart got out=%0d dir=%b exp 11 1", b1.out, b1.dir);
    end
    b1.enable = 1'b0;
  endtask

  task automatic test_wrap_down();
    logic [7:0] eo [5] = '{8'd13, 8'd12, 8'd11, 8'd10, 8'd13};
    logic       et [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    b1.mode       = 2'b01;
    b1.load       = 1'b1;
    b1.load_value = 8'd10;
    tick();
    b1.load   = 1'b0;
    b1.enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (b1.out !== eo[i] || b1.tc !== et[i] || b1.dir !== 1'b0) begin
        n_err++;
        $display("FAIL wrap_down[%0d] got out=%0d tc=%b dir=%b exp %0d %b 0",
                 i, b1.out, b1.tc, b1.dir, eo[i], et[i]);
      end
    end
    b1.enable = 1'b0;
    n_cmp++;
    if (b1.lap_count !== 8'd2) begin
      n_err++;
      $display("FAIL wrap_down_lap got %0d exp 2", b1.lap_count);
    end
  endtask

  task automatic test_lap_wrap();
    do_reset();
    b1.mode   = 2'b00;
    b1.enable = 1'b1;
    for (int i = 0; i < 1023; i++) tick();
    n_cmp++;
    if (b1.lap_count !== 8'd255 || b1.out !== 8'd13) begin
      n_err++;
      $display("FAIL lap_255 got lap=%0d out=%0d exp 255 13",
               b1.lap_count, b1.out);
    end
    tick();
    n_cmp++;
    if (b1.lap_count !== 8'd0 || b1.tc !== 1'b1 || b1.out !== 8'd10) begin
      n_err++;
      $display("FAIL lap_wrap got lap=%0d tc=%b out=%0d exp 0 1 10",
               b1.lap_count, b1.tc, b1.out);
    end
    b1.enable = 1'b0;
  endtask

  initial begin
    b1.enable     = 1'b0;
    b1.mode       = 2'b00;
    b1.load       = 1'b0;
    b1.load_value = 8'd0;
    b2.enable     = 1'b0;
    b2.mode       = 2'b00;
    b2.load       = 1'b0;
    b2.load_value = 8'd0;
    test_reset();
    test_wrap_up();
    test_ping_pong();
    test_saturate();
    test_load();
    test_pp_boundary();
    test_mid_run();
    test_wrap_down();
    test_lap_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
